seq_detector_param: RTL
=======================

// Module: seq_detector_param
// PURPOSE
//   Parametrised Mealy sequence detector: next generation of the fixed-pattern overlapping detector.
//   Adds configurable pattern length, a runtime-loadable pattern, a din qualifier,
//   per-cycle overlap/non-overlap mode and a saturating match counter.
//   Sits on a serial bit stream; dout is a same-cycle (Mealy) match strobe for downstream logic.
// PARAMETERS
//   PATTERN_LEN  4        pattern length in bits, legal range 2..32
//   PATTERN      4'b1011  reset-time pattern; PATTERN[PATTERN_LEN-1] is the first bit received
//   CNT_W        8        width of match counter
// PORTS
//   clk        in   1            rising-edge clock
//   reset_n    in   1            asynchronous, active-low reset
//   en         in   1            din qualifier; din is sampled only when en=1
//   din        in   1            serial data bit
//   overlap    in   1            1 = overlapping detection, 0 = non-overlapping
//   pat_load   in   1            load pat_in as the new pattern
//   pat_in     in   PATTERN_LEN  new pattern, same bit order as PATTERN
//   dout       out  1            Mealy match strobe (combinational)
//   match_cnt  out  CNT_W        number of matches since reset/load, saturating
//   cnt_sat    out  1            1 while match_cnt == all-ones
// BEHAVIOUR
//   State: pat_r[PATTERN_LEN-1:0], hist[PATTERN_LEN-2:0] (last accepted bits, newest in bit 0),
//          fill (0..PATTERN_LEN-1, count of valid history bits, saturating), match_cnt.
//   Reset (reset_n=0, async): pat_r<=PATTERN, hist<=0, fill<=0, match_cnt<=0.
//     Outputs: dout=0, match_cnt=0, cnt_sat=0. Applies immediately, mid-stream included.
//   Match term (combinational): en & ~pat_load & (fill==PATTERN_LEN-1) & ({hist,din}==pat_r).
//   dout = match term; zero latency, valid in the same cycle as the final pattern bit.
//   On clock edge, priority order:
//     1. pat_load=1: pat_r<=pat_in, hist<=0, fill<=0, match_cnt<=0. A din in the same
//        cycle is discarded even if en=1; dout=0 in that cycle.
//     2. en=0: no state change; dout=0.
//     3. en=1, no match: hist<={hist[PATTERN_LEN-3:0],din}; fill<=min(fill+1,PATTERN_LEN-1).
//     4. en=1, match, overlap=1: same shift as 3; fill holds at PATTERN_LEN-1, so the
//        suffix of the match can prefix the next one.
//     5. en=1, match, overlap=0: hist<=0, fill<=0. The next match needs PATTERN_LEN fresh bits.
//     In cases 4 and 5, match_cnt<=match_cnt+1 unless it is all-ones, where it holds (saturates).
//   overlap is sampled every cycle; only its value in a match cycle matters.
//   Gaps with en=0 are transparent: pattern bits may be separated by any number of idle cycles.
//   cnt_sat = &match_cnt (combinational from register).
//   din/en/overlap are synchronous to clk; no internal synchroniser.
// TESTING
//   1. Defaults; after reset release, en=1, din=1,0,1,1,0,1,1 with overlap=1 -> dout=1 on
//      bits 4 and 7; match_cnt=2.
//   2. Same stream with overlap=0 -> dout=1 on bit 4 only; match_cnt=1.
//   3. Stream 1,0,1,1 with en=0 for 3 cycles between each bit -> single dout pulse,
//      coincident with the last bit; dout=0 in every en=0 cycle.
//   4. After 1,0,1 accepted, pat_load=1 with pat_in=4'b0110 and en=1, din=1 -> dout=0,
//      match_cnt=0; then 0,1,1,0 -> dout=1 on the 4th bit.
//   5. After 1,0,1 accepted, pull reset_n low between clock edges -> outputs clear with no
//      clock edge; after release, a single 1 -> dout=0.
//   6. CNT_W=2, overlap=1, stream 1011011011011 -> match_cnt 1,2,3,3;
//      cnt_sat=1 from the 3rd match; dout still pulses on the 4th.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param
// Parametrised Mealy sequence detector on a serial bit stream. The pattern is
// runtime-loadable, din is qualified by en, and detection can switch between
// overlapping and non-overlapping mode every cycle. Matches are counted in a
// saturating counter. dout is a same-cycle strobe on the final pattern bit.
module seq_detector_param #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter int                     CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic                   din,
    input  logic                   overlap,
    input  logic                   pat_load,
    input  logic [PATTERN_LEN-1:0] pat_in,
    output logic                   dout,
    output logic [CNT_W-1:0]       match_cnt,
    output logic                   cnt_sat
);

    // fill only needs to reach PATTERN_LEN-1: once that many bits are held,
    // the incoming din completes a full-length window.
    localparam int               FILL_W    = $clog2(PATTERN_LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN - 1);

    logic [PATTERN_LEN-1:0] pat_q,  pat_d;
    logic [PATTERN_LEN-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]       cnt_q,  cnt_d;

    logic [PATTERN_LEN-1:0] window;
    logic                   full;
    logic                   match;
    logic                   sat;

    // Candidate window is the stored history with the live bit appended, so
    // the match is visible in the same cycle as the last pattern bit.
    assign window    = {hist_q, din};
    assign full      = (fill_q == FILL_FULL);
    assign match     = en & ~pat_load & full & (window == pat_q);
    assign sat       = &cnt_q;

    assign dout      = match;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat;

    // Next-state selection: a load overrides everything, idle cycles freeze
    // state, and a non-overlapping match flushes the history.
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (en) begin
            if (match && !overlap) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[PATTERN_LEN-2:0];
                if (!full) begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
            if (match && !sat) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset restores the build-time pattern and clears history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
